// File: rtl/fetch_mem_arbiter.sv
// Single-port SRAM arbiter shared by the IF and MEM pipeline stages.
// MEM has priority; each grant runs WAIT_CYCLES access cycles followed by one ready cycle.
module fetch_mem_arbiter #(
    parameter int N           = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ifReq,
    input  logic [N-1:0] ifAddr,
    output logic [N-1:0] ifRdata,
    output logic         ifReady,
    output logic         freezeIF,
    input  logic         memReq,
    input  logic         memWe,
    input  logic [N-1:0] memAddr,
    input  logic [N-1:0] memWdata,
    output logic [N-1:0] memRdata,
    output logic         memReady,
    output logic         sramEn,
    output logic         sramWe,
    output logic [N-1:0] sramAddr,
    output logic [N-1:0] sramWdata,
    input  logic [N-1:0] sramRdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [N-1:0]  addr_q, addr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [N-1:0]  if_rdata_q, if_rdata_d;
    logic [N-1:0]  mem_rdata_q, mem_rdata_d;

    // Next-state: grant in IDLE, count access cycles, capture read data on the last one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (memReq) begin
                    owner_d = OWN_MEM;
                    we_d    = memWe;
                    addr_d  = memAddr;
                    wdata_d = memWdata;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_ACCESS;
                end else if (ifReq) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = ifAddr;
                    wdata_d = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DONE;
                    // Writes leave both read-data registers untouched.
                    if (!we_q && (owner_q == OWN_MEM)) begin
                        mem_rdata_d = sramRdata;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                    if (!we_q && (owner_q == OWN_IF)) begin
                        if_rdata_d = sramRdata;
                    end else begin
                        if_rdata_d = if_rdata_q;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ACCESS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= {N{1'b0}};
            wdata_q     <= {N{1'b0}};
            if_rdata_q  <= {N{1'b0}};
            mem_rdata_q <= {N{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // SRAM strobes and ready pulses decode from registered state only.
    assign sramEn    = (state_q == S_ACCESS);
    assign sramWe    = (state_q == S_ACCESS) & we_q;
    assign sramAddr  = addr_q;
    assign sramWdata = wdata_q;
    assign ifReady   = (state_q == S_DONE) & (owner_q == OWN_IF);
    assign memReady  = (state_q == S_DONE) & (owner_q == OWN_MEM);
    assign ifRdata   = if_rdata_q;
    assign memRdata  = mem_rdata_q;
    assign freezeIF  = ifReq & ~ifReady;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Scoreboard bench for fetch_mem_arbiter: three instances (WAIT_CYCLES 2, 1, 4)
// share clock/reset; a monitor pops expected ready events and checks cycle and data.
module tb_fetch_mem_arbiter;

    localparam int WS [3] = '{2, 1, 4};

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q_if[$];
    exp_t        q_mem[$];

    logic        if_req    [3];
    logic [31:0] if_addr   [3];
    logic [31:0] if_rdata  [3];
    logic        if_ready  [3];
    logic        freeze    [3];
    logic        mem_req   [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic        mem_ready [3];
    logic        sram_en   [3];
    logic        sram_we   [3];
    logic [31:0] sram_addr [3];
    logic [31:0] sram_wdata[3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_word(logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hE3A0_1005;
        return {~a[15:0], a[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int          en_cnt;
        logic [31:0] rdata_s;

        // SRAM model: data is only valid in the last access cycle of a transaction.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) en_cnt <= 0;
            else if (sram_en[g]) en_cnt <= en_cnt + 1;
            else en_cnt <= 0;
        end
        assign rdata_s = (en_cnt == WS[g] - 1) ? model_word(sram_addr[g]) : 32'hBAD0_BAD0;

        fetch_mem_arbiter #(.N(32), .WAIT_CYCLES(WS[g])) dut (
            .clk(clk), .rst(rst),
            .ifReq(if_req[g]), .ifAddr(if_addr[g]), .ifRdata(if_rdata[g]),
            .ifReady(if_ready[g]), .freezeIF(freeze[g]),
            .memReq(mem_req[g]), .memWe(mem_we[g]), .memAddr(mem_addr[g]),
            .memWdata(mem_wdata[g]), .memRdata(mem_rdata[g]), .memReady(mem_ready[g]),
            .sramEn(sram_en[g]), .sramWe(sram_we[g]), .sramAddr(sram_addr[g]),
            .sramWdata(sram_wdata[g]), .sramRdata(rdata_s)
        );
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (if_ready[k] === 1'b1) begin
                if (q_if.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL if_unexpected_ready dut=%0d actual=1 required=0 (cycle %0d)", k, cyc);
                end else begin
                    e = q_if.pop_front();
                    chk("if_dut", k, e.dut);
                    chk("if_ready_cycle", cyc, e.cyc);
                    chk("if_rdata", if_rdata[k], e.data);
                end
            end
            if (mem_ready[k] === 1'b1) begin
                if (q_mem.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_unexpected_ready dut=%0d actual=1 required=0 (cycle %0d)", k, cyc);
                end else begin
                    e = q_mem.pop_front();
                    chk("mem_dut", k, e.dut);
                    chk("mem_ready_cycle", cyc, e.cyc);
                    chk("mem_rdata", mem_rdata[k], e.data);
                end
            end
        end
    end

    task automatic push(bit is_mem, int k, logic [31:0] data, int at);
        exp_t e;
        e.dut = k; e.data = data; e.cyc = at;
        if (is_mem) q_mem.push_back(e);
        else q_if.push_back(e);
    endtask

    // Issue one request, hold it until ready, drop it after the sampling edge.
    task automatic run_req(int k, bit is_mem, bit we, logic [31:0] addr,
                           logic [31:0] wdata, logic [31:0] exp);
        push(is_mem, k, exp, cyc + WS[k] + 1);
        if (is_mem) begin
            mem_req[k] = 1'b1; mem_we[k] = we; mem_addr[k] = addr; mem_wdata[k] = wdata;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        repeat (WS[k] + 2) @(posedge clk);
        #1;
        mem_req[k] = 1'b0; mem_we[k] = 1'b0; if_req[k] = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int k = 0; k < 3; k++) begin
            if_req[k] = 1'b0; if_addr[k] = 32'h0; mem_req[k] = 1'b0; mem_we[k] = 1'b0;
            mem_addr[k] = 32'h0; mem_wdata[k] = 32'h0;
        end
        if_req[0] = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_sram_en", sram_en[k], 1'b0);
            chk("rst_sram_we", sram_we[k], 1'b0);
            chk("rst_sram_addr", sram_addr[k], 32'h0);
            chk("rst_if_ready", if_ready[k], 1'b0);
            chk("rst_mem_ready", mem_ready[k], 1'b0);
            chk("rst_if_rdata", if_rdata[k], 32'h0);
            chk("rst_freeze", freeze[k], (k == 0) ? 1'b1 : 1'b0);
        end
        if_req[0] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Reset asserted mid-ACCESS of a write aborts with no clock edge.
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'h300; mem_wdata[0] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("abort_pre_en", sram_en[0], 1'b1);
        chk("abort_pre_we", sram_we[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_sram_en", sram_en[0], 1'b0);
        chk("abort_sram_we", sram_we[0], 1'b0);
        chk("abort_if_ready", if_ready[0], 1'b0);
        chk("abort_mem_ready", mem_ready[0], 1'b0);
        mem_req[0] = 1'b0; mem_we[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // IF read W=2: also proves the FSM restarted from IDLE.
        t0 = cyc;
        push(1'b0, 0, 32'hE3A0_1005, t0 + 3);
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("ifrd_freeze_c%0d", i), freeze[0], (i <= 2) ? 1'b1 : 1'b0);
            chk($sformatf("ifrd_sram_en_c%0d", i), sram_en[0], (i == 1 || i == 2) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end
        if_req[0] = 1'b0;

        // Simultaneous requests: MEM first, IF after.
        t0 = cyc;
        push(1'b1, 0, 32'hFEFF_0100, t0 + 3);
        push(1'b0, 0, 32'hFFDF_0020, t0 + 7);
        if_req[0] = 1'b1; if_addr[0] = 32'h20;
        mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("simul_freeze_c%0d", i), freeze[0], (i <= 6) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
            if (i == 3) mem_req[0] = 1'b0;
        end
        if_req[0] = 1'b0;

        // MEM write: SRAM strobes for two cycles, read-data registers untouched.
        t0 = cyc;
        push(1'b1, 0, 32'hFEFF_0100, t0 + 3);
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'h200; mem_wdata[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("wr_sram_we_c%0d", i), sram_we[0], (i == 1 || i == 2) ? 1'b1 : 1'b0);
            if (i == 1 || i == 2) begin
                chk("wr_sram_addr", sram_addr[0], 32'h200);
                chk("wr_sram_wdata", sram_wdata[0], 32'hDEAD_BEEF);
            end
            @(posedge clk); #1;
        end
        mem_req[0] = 1'b0; mem_we[0] = 1'b0;
        chk("wr_if_rdata_kept", if_rdata[0], 32'hFFDF_0020);

        // Withdrawal: request dropped in cycle 1 still completes, nothing follows.
        t0 = cyc;
        push(1'b0, 0, 32'hE3A0_1005, t0 + 3);
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("wd_sram_en_c%0d", i), sram_en[0], (i == 1 || i == 2) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
            if (i == 0) if_req[0] = 1'b0;
        end

        // WAIT_CYCLES sweep: 1 and 4.
        run_req(1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hFFBF_0040);
        run_req(1, 1'b1, 1'b0, 32'h80, 32'h0, 32'hFF7F_0080);
        run_req(2, 1'b0, 1'b0, 32'h40, 32'h0, 32'hFFBF_0040);
        run_req(2, 1'b1, 1'b0, 32'h80, 32'h0, 32'hFF7F_0080);
        run_req(2, 1'b1, 1'b1, 32'h84, 32'h5555_AAAA, 32'hFF7F_0080);

        repeat (6) @(posedge clk);
        #1;
        chk("q_if_left", q_if.size(), 32'd0);
        chk("q_mem_left", q_mem.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
